// File: rtl/io_mem_arbiter.sv
// Two-requester arbiter in front of the IO DMem port; a grant is held from request
// through read response so responses need no tags. `IO_ARB_FIXED_PRIO_EN` selects fixed priority.
module io_mem_arbiter #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  input  logic              req0_write,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  input  logic              req1_write,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [DWIDTH-1:0] resp0_data,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DWIDTH-1:0] resp1_data,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [AWIDTH-1:0] mem_req_addr,
  output logic [DWIDTH-1:0] mem_req_data,
  output logic              mem_req_write,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic [DWIDTH-1:0] mem_resp_data,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       gnt_valid, gnt_write, gnt_resp_ready;
  logic       in_req, in_resp, req_fire, resp_fire, rr_adv;

`ifdef IO_ARB_FIXED_PRIO_EN
  // rr_ptr never leaves 0, so a tie always goes to requester 0
  assign rr_adv = 1'b0;
`else
  assign rr_adv = ~grant_q;
`endif

  assign in_req         = (state_q == S_REQ);
  assign in_resp        = (state_q == S_RESP);
  assign gnt_valid      = grant_q ? req1_valid  : req0_valid;
  assign gnt_write      = grant_q ? req1_write  : req0_write;
  assign gnt_resp_ready = grant_q ? resp1_ready : resp0_ready;

  assign mem_req_addr   = grant_q ? req1_addr : req0_addr;
  assign mem_req_data   = grant_q ? req1_data : req0_data;
  assign mem_req_write  = gnt_write;
  assign mem_req_valid  = in_req & gnt_valid;
  assign req0_ready     = in_req & ~grant_q & mem_req_ready;
  assign req1_ready     = in_req &  grant_q & mem_req_ready;

  assign mem_resp_ready = in_resp & gnt_resp_ready;
  assign resp0_valid    = in_resp & ~grant_q & mem_resp_valid;
  assign resp1_valid    = in_resp &  grant_q & mem_resp_valid;
  assign resp0_data     = mem_resp_data;
  assign resp1_data     = mem_resp_data;

  assign req_fire  = mem_req_valid & mem_req_ready;
  assign resp_fire = mem_resp_valid & mem_resp_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = S_REQ;
          grant_d = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
        end
      end
      S_REQ: begin
        // a granted requester withdrawing before fire is tolerated: rearbitrate, no pointer move
        if (!gnt_valid) begin
          state_d = S_IDLE;
        end else if (req_fire) begin
          if (gnt_write) begin
            state_d  = S_IDLE;
            rr_ptr_d = rr_adv;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          state_d  = S_IDLE;
          rr_ptr_d = rr_adv;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: tb/tb_io_mem_arbiter.sv
// Scoreboard bench for io_mem_arbiter: stimulus pushes expected grants/requests/responses,
// a negedge monitor pops and compares on every downstream fire and response handshake.
module tb_io_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
  logic        req0_write, req1_write, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic        resp0_valid, resp1_valid, resp0_ready, resp1_ready;
  logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
  logic        mem_req_write, mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;

  io_mem_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_addr(req0_addr), .req0_data(req0_data), .req0_write(req0_write),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_addr(req1_addr), .req1_data(req1_data), .req1_write(req1_write),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .resp0_data(resp0_data), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_data(resp1_data), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_write(mem_req_write),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t        exp_req0[$], exp_req1[$];
  logic [31:0] exp_resp0[$], exp_resp1[$];
  logic        exp_gnt[$];
  logic [31:0] mem [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event, expected none", nm);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // the arbiter's outputs that must all be low in IDLE and under reset
  function automatic logic [5:0] vr_outs();
    return {req0_ready, req1_ready, resp0_valid, resp1_valid, mem_req_valid, mem_resp_ready};
  endfunction

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_valid && mem_req_ready) begin
          req_t got, e;
          got = '{w: mem_req_write, a: mem_req_addr, d: mem_req_data};
          if (exp_gnt.size() == 0) miss("unexpected_fire");
          else chk("grant_port", {95'd0, req1_ready}, {95'd0, exp_gnt.pop_front()});
          chk("one_hot_ready", {94'd0, req0_ready, req1_ready},
              req1_ready ? 96'd1 : 96'd2);
          if (req1_ready) begin
            if (exp_req1.size() == 0) miss("unexpected_req1");
            else begin e = exp_req1.pop_front(); chk("req1_fields", 96'(got), 96'(e)); end
          end else begin
            if (exp_req0.size() == 0) miss("unexpected_req0");
            else begin e = exp_req0.pop_front(); chk("req0_fields", 96'(got), 96'(e)); end
          end
        end
        if (resp0_valid && resp1_valid) miss("both_resp_valid");
        if (resp0_valid && exp_resp0.size() == 0) miss("spurious_resp0");
        if (resp1_valid && exp_resp1.size() == 0) miss("spurious_resp1");
        if (resp0_valid && resp0_ready && exp_resp0.size() != 0)
          chk("resp0_data", {64'd0, resp0_data}, {64'd0, exp_resp0.pop_front()});
        if (resp1_valid && resp1_ready && exp_resp1.size() != 0)
          chk("resp1_data", {64'd0, resp1_data}, {64'd0, exp_resp1.pop_front()});
      end
    end
  end

  // downstream memory: read data appears two cycles after the fire edge
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req_valid && mem_req_ready) begin
        if (mem_req_write) mem[mem_req_addr] = mem_req_data;
        else begin
          logic [31:0] a;
          a = mem_req_addr;
          @(posedge clk);
          @(posedge clk);
          @(posedge clk); #1;
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem[a];
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rst) begin mem_resp_valid = 1'b0; break; end
            if (mem_resp_ready) begin step(); mem_resp_valid = 1'b0; break; end
          end
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rexp);
    logic ok;
    if (p == 0) begin
      exp_req0.push_back('{w: w, a: a, d: d});
      if (!w) exp_resp0.push_back(rexp);
      req0_write = w; req0_addr = a; req0_data = d; req0_valid = 1'b1;
    end else begin
      exp_req1.push_back('{w: w, a: a, d: d});
      if (!w) exp_resp1.push_back(rexp);
      req1_write = w; req1_addr = a; req1_data = d; req1_valid = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? req0_ready : req1_ready;
    end
    if (!ok) chk("req_accept_timeout", 96'd0, 96'd1);
    step();
  endtask

  task automatic drop(input int p);
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      left = exp_req0.size() + exp_req1.size() + exp_resp0.size() + exp_resp1.size()
           + exp_gnt.size();
      if (left == 0 && !mem_resp_valid) break;
    end
    chk("drain_pending", 96'(left), 96'd0);
    chk("drain_idle_outs", {90'd0, vr_outs()}, 96'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd0 [4];
    logic [31:0] rd1 [4];
    rd0 = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    rd1 = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    mem[32'h20] = 32'h1234_5678;
    mem[32'h30] = 32'hC0FF_EE00;
    mem[32'h34] = 32'hBADC_0DE1;
    mem[32'h44] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4*i)] = rd0[i];
      mem[32'h200 + 32'(4*i)] = rd1[i];
    end
    rst = 1'b1;
    {req0_valid, req1_valid, req0_write, req1_write} = '0;
    {req0_addr, req1_addr, req0_data, req1_data} = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1; mem_req_ready = 1'b1;

    // reset state
    step();
    @(negedge clk);
    chk("reset_outs", {90'd0, vr_outs()}, 96'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", {90'd0, vr_outs()}, 96'd0);

    // single write on port 0
    step();
    exp_gnt.push_back(1'b0);
    exp_req0.push_back('{w: 1'b1, a: 32'h10, d: 32'hDEAD_BEEF});
    req0_addr = 32'h10; req0_data = 32'hDEAD_BEEF; req0_write = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    chk("arb_cycle_no_valid", {95'd0, mem_req_valid}, 96'd0);
    step();
    @(negedge clk);
    chk("wr_req_valid_ready", {93'd0, mem_req_valid, req0_ready, mem_req_write}, 96'd7);
    step(); req0_valid = 1'b0;
    @(negedge clk);
    chk("wr_back_idle", {90'd0, vr_outs()}, 96'd0);
    drain();

    // single read on port 1
    exp_gnt.push_back(1'b1);
    issue(1, 1'b0, 32'h20, 32'h0, 32'h1234_5678);
    drop(1);
    drain();

    // both ports reading continuously
`ifdef IO_ARB_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_gnt = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'h100 + 32'(4*i), 32'h0, rd0[i]);
        drop(0);
      end
      begin
        for (int j = 0; j < 4; j++) issue(1, 1'b0, 32'h200 + 32'(4*j), 32'h0, rd1[j]);
        drop(1);
      end
    join
    drain();

    // response backpressure on port 0 while port 1 waits
    resp0_ready = 1'b0;
    exp_gnt = '{0, 1};
    fork
      begin issue(0, 1'b0, 32'h30, 32'h0, 32'hC0FF_EE00); drop(0); end
      begin step(); issue(1, 1'b0, 32'h34, 32'h0, 32'hBADC_0DE1); drop(1); end
      begin
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
          @(negedge clk);
          seen = resp0_valid;
        end
        chk("bp_resp0_seen", {95'd0, seen}, 96'd1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_hold", {93'd0, req1_ready, mem_req_valid, resp0_valid}, 96'd1);
          chk("bp_data", {64'd0, resp0_data}, {64'd0, 32'hC0FF_EE00});
        end
        step(); resp0_ready = 1'b1;
      end
    join
    drain();

    // reset while in RESP; pointer would favour port 1 without the reset
    exp_gnt = '{0, 0};
    issue(0, 1'b1, 32'h40, 32'h55AA, 32'h0);
    drop(0);
    resp0_ready = 1'b0;
    issue(0, 1'b0, 32'h44, 32'h0, 32'h4444_4444);
    drop(0);
    for (int i = 0; i < 20 && !resp0_valid; i++) @(negedge clk);
    chk("pre_reset_in_resp", {95'd0, resp0_valid}, 96'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    exp_resp0.delete();
    #1;
    chk("reset_same_cycle", {90'd0, vr_outs()}, 96'd0);
    @(negedge clk);
    chk("reset_outs_resp", {90'd0, vr_outs()}, 96'd0);
    step(); rst = 1'b0; resp0_ready = 1'b1;
    exp_gnt = '{0, 1};
    fork
      begin issue(0, 1'b1, 32'h48, 32'h4848, 32'h0); drop(0); end
      begin issue(1, 1'b1, 32'h4C, 32'h4C4C, 32'h0); drop(1); end
    join
    drain();

    // both ports writing continuously
`ifdef IO_ARB_FIXED_PRIO_EN
    exp_gnt = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    exp_gnt = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, 1'b1, 32'h80 + 32'(4*i), 32'h600D_0000 + 32'(i), 32'h0);
        drop(0);
      end
      begin
        for (int j = 0; j < 4; j++) issue(1, 1'b1, 32'h90 + 32'(4*j), 32'h700D_0000 + 32'(j), 32'h0);
        drop(1);
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
